pin_debouncer: RTL and testbench

Per-channel synchronizer and debouncer for raw board pins such as push-buttons and switches. It sits directly upstream of the gate-evaluation logic and drives its iA/iB/iD/iE inputs with clean, clock-synchronous levels. It also produces one-cycle rise/fall pulses for downstream sequential consumers. All channels are identical and fully independent.

---
 rtl/pin_debouncer_if.sv | 27 ++
 rtl/pin_debouncer.sv | 77 +++++++
 tb/tb_pin_debouncer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pin_debouncer_if.sv
// Pin bundle between raw board pins and the debouncer.
// Slave side is the debouncer; master side drives the raw pins.
interface pin_debouncer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] iRaw;
  logic [WIDTH-1:0] oLevel;
  logic [WIDTH-1:0] oRise;
  logic [WIDTH-1:0] oFall;
  logic             oChanged;

  modport master (
    output iRaw,
    input  oLevel,
    input  oRise,
    input  oFall,
    input  oChanged
  );

  modport slave (
    input  iRaw,
    output oLevel,
    output oRise,
    output oFall,
    output oChanged
  );
endinterface

// File: rtl/pin_debouncer.sv
// Two-flop synchronizer plus per-channel stability counter.
// Emits clean levels and one-cycle rise/fall/changed pulses.
module pin_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_WIDTH     = 16
) (
  input logic           iClk,
  input logic           iRstN,
  pin_debouncer_if.slave pins
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;
  logic [CNT_WIDTH-1:0] cnt [WIDTH];

  logic [WIDTH-1:0] level_nx;
  logic [WIDTH-1:0] rise_nx;
  logic [WIDTH-1:0] fall_nx;
  logic [CNT_WIDTH-1:0] cnt_nx [WIDTH];

  // Per channel: count mismatch cycles, accept s2 on the last one.
  always_comb begin
    level_nx = level;
    rise_nx  = '0;
    fall_nx  = '0;
    for (int n = 0; n < WIDTH; n++) begin
      cnt_nx[n] = cnt[n];
      if (s2[n] == level[n]) begin
        cnt_nx[n] = '0;
      end else if (cnt[n] == CNT_MAX) begin
        cnt_nx[n]   = '0;
        level_nx[n] = s2[n];
        rise_nx[n]  = s2[n];
        fall_nx[n]  = ~s2[n];
      end else begin
        cnt_nx[n] = cnt[n] + CNT_WIDTH'(1);
      end
    end
  end

  // State and registered outputs; reset clears all without pulsing.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      s1      <= '0;
      s2      <= '0;
      level   <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
      for (int n = 0; n < WIDTH; n++) begin
        cnt[n] <= '0;
      end
    end else begin
      s1      <= pins.iRaw;
      s2      <= s1;
      level   <= level_nx;
      rise    <= rise_nx;
      fall    <= fall_nx;
      changed <= |(rise_nx | fall_nx);
      for (int n = 0; n < WIDTH; n++) begin
        cnt[n] <= cnt_nx[n];
      end
    end
  end

  assign pins.oLevel   = level;
  assign pins.oRise    = rise;
  assign pins.oFall    = fall;
  assign pins.oChanged = changed;
endmodule

// File: tb/tb_pin_debouncer.sv
// Directed bench for pin_debouncer with a per-edge scoreboard.
// Driver queues expected outputs; monitor pops after each edge.
module tb_pin_debouncer;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pin_debouncer_if #(.WIDTH(4)) pins ();

  pin_debouncer #(
    .WIDTH(4),
    .STABLE_CYCLES(4),
    .CNT_WIDTH(3)
  ) dut (
    .iClk(clk),
    .iRstN(rst_n),
    .pins(pins.slave)
  );

  typedef struct {
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  // Drive one edge worth of inputs and queue the outputs after it.
  task automatic step(input logic rst, input logic [3:0] raw,
                      input logic [3:0] lvl, input logic [3:0] rise,
                      input logic [3:0] fall, input logic chg,
                      input string tag);
    exp_t x;
    @(negedge clk);
    rst_n     = rst;
    pins.iRaw = raw;
    x.lvl  = lvl;
    x.rise = rise;
    x.fall = fall;
    x.chg  = chg;
    x.tag  = tag;
    q.push_back(x);
  endtask

  task automatic hold(input int n, input logic rst,
                      input logic [3:0] raw, input logic [3:0] lvl,
                      input string tag);
    for (int i = 0; i < n; i++) begin
      step(rst, raw, lvl, 4'h0, 4'h0, 1'b0, tag);
    end
  endtask

  // New raw held: 5 edges at old level, change on the 6th, then quiet.
  task automatic accept(input logic [3:0] raw, input logic [3:0] old_lvl,
                        input logic [3:0] new_lvl, input logic [3:0] rise,
                        input logic [3:0] fall, input string tag);
    hold(5, 1'b1, raw, old_lvl, {tag, "_wait"});
    step(1'b1, raw, new_lvl, rise, fall, 1'b1, {tag, "_edge"});
    step(1'b1, raw, new_lvl, 4'h0, 4'h0, 1'b0, {tag, "_after"});
  endtask

  // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (pins.oLevel !== e.lvl || pins.oRise !== e.rise ||
          pins.oFall !== e.fall || pins.oChanged !== e.chg) begin
        errors++;
        $display("FAIL %s: got lvl=%h rise=%h fall=%h chg=%b, want lvl=%h rise=%h fall=%h chg=%b",
                 e.tag, pins.oLevel, pins.oRise, pins.oFall, pins.oChanged,
                 e.lvl, e.rise, e.fall, e.chg);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    pins.iRaw = 4'hF;

    hold(3, 1'b0, 4'hF, 4'h0, "t1_reset");
    accept(4'hF, 4'h0, 4'hF, 4'hF, 4'h0, "t1_rise");
    accept(4'h0, 4'hF, 4'h0, 4'h0, 4'hF, "t1_fall");

    hold(3, 1'b1, 4'h1, 4'h0, "t2_short");
    hold(8, 1'b1, 4'h0, 4'h0, "t2_quiet");

    step(1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0, "t3_b1");
    step(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, "t3_b2");
    step(1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0, "t3_b3");
    step(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, "t3_b4");
    accept(4'h2, 4'h0, 4'h2, 4'h2, 4'h0, "t3_rise");

    accept(4'h5, 4'h2, 4'h5, 4'h5, 4'h2, "t4_prep");
    accept(4'h4, 4'h5, 4'h4, 4'h0, 4'h1, "t4_fall");

    accept(4'h2, 4'h4, 4'h2, 4'h2, 4'h4, "t6_swap");

    hold(5, 1'b1, 4'h4, 4'h2, "t5_count");
    step(1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0, "t5_reset");
    accept(4'h4, 4'h0, 4'h4, 4'h4, 4'h0, "t5_requal");

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
